// File: rtl/and_operand_loader_pkg.sv
// Shared definitions for the 4-bit AND datapath: default operand width and
// the loader state encoding used by both the loader and the AND stage.
package and_operand_loader_pkg;

  localparam int unsigned AND_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_A  = 2'd1,
    ST_LOAD_B  = 2'd2,
    ST_PRESENT = 2'd3
  } ld_state_e;

  // Bit counter width: one extra bit beyond clog2 so WIDTH itself is representable
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// WIDTH-bit serial-in/parallel-out shift register, MSB first, with
// synchronous clear (priority over enable) and synchronous active-low reset.
module sipo_shift #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/and_operand_loader.sv
// Serial-to-parallel operand front end for the AND stage: assembles A then B
// from one MSB-first serial line and presents the pair under valid/ready.
module and_operand_loader
  import and_operand_loader_pkg::*;
#(
  parameter int unsigned WIDTH = AND_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             busy
);

  localparam int unsigned CW = cnt_width(WIDTH);

  ld_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] ahold_q;
  logic [WIDTH-1:0] word_c;
  logic             sh_clr, sh_en;
  logic             ahold_ld, out_ld;
  logic             last_bit_c;

  sipo_shift #(.WIDTH(WIDTH)) u_sipo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sh_clr),
    .en    (sh_en),
    .din   (ser_in),
    .q     (sh_q)
  );

  // Full word as it will look after the bit currently on ser_in is shifted in
  assign word_c     = {sh_q[WIDTH-2:0], ser_in};
  assign last_bit_c = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_clr   = 1'b0;
    sh_en    = 1'b0;
    ahold_ld = 1'b0;
    out_ld   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_A;
          cnt_d   = '0;
          sh_clr  = 1'b1;
        end
      end
      ST_LOAD_A: begin
        if (ser_valid) begin
          sh_en = 1'b1;
          if (last_bit_c) begin
            ahold_ld = 1'b1;
            cnt_d    = '0;
            state_d  = ST_LOAD_B;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_LOAD_B: begin
        if (ser_valid) begin
          sh_en = 1'b1;
          if (last_bit_c) begin
            out_ld  = 1'b1;
            cnt_d   = '0;
            state_d = ST_PRESENT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_PRESENT: begin
        if (op_ready) begin
          if (start) begin
            state_d = ST_LOAD_A;
            cnt_d   = '0;
            sh_clr  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand registers and status flags, the latter registered from next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ahold_q   <= '0;
      A_out     <= '0;
      B_out     <= '0;
      op_valid  <= 1'b0;
      ser_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (ahold_ld) begin
        ahold_q <= word_c;
      end
      if (out_ld) begin
        A_out <= ahold_q;
        B_out <= word_c;
      end
      op_valid  <= (state_d == ST_PRESENT);
      ser_ready <= (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
      busy      <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_and_operand_loader.sv
// Self-checking bench for and_operand_loader: scoreboard of expected A/B/AND
// triples pushed when a frame is sent and popped when op_valid appears.
module tb_and_operand_loader;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         ser_in;
  logic         ser_valid;
  logic         ser_ready;
  logic [W-1:0] A_out;
  logic [W-1:0] B_out;
  logic         op_valid;
  logic         op_ready;
  logic         busy;

  int tests  = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
  } exp_t;

  exp_t sb[$];

  and_operand_loader #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .A_out     (A_out),
    .B_out     (B_out),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Shift both operands in, MSB first; optional stall cycle before every bit
  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input bit stall,
                            input bit push);
    logic [2*W-1:0] bits;
    bits = {a, b};
    for (int i = 2*W-1; i >= 0; i--) begin
      if (stall) begin
        ser_valid = 1'b0;
        ser_in    = 1'b1;
        tick();
      end
      chk("ser_ready_in_load", W'(ser_ready), W'(1));
      chk("op_valid_during_load", W'(op_valid), W'(0));
      ser_valid = 1'b1;
      ser_in    = bits[i];
      tick();
    end
    ser_valid = 1'b0;
    ser_in    = 1'b0;
    if (push) sb.push_back('{a: a, b: b, y: a & b});
  endtask

  task automatic expect_pair(input string name);
    exp_t e;
    int   n;
    n = 0;
    while (op_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (op_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: op_valid %b expected 1", name, op_valid);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: pair %b/%b with empty scoreboard", name, A_out, B_out);
    end else begin
      e = sb.pop_front();
      chk({name, "_A"}, A_out, e.a);
      chk({name, "_B"}, B_out, e.b);
      chk({name, "_and"}, A_out & B_out, e.y);
    end
  endtask

  task automatic handshake();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; ser_valid = 1'b1; ser_in = 1'b1; op_ready = 1'b0;
    tick();
    tick();
    chk("rst_A", A_out, '0);
    chk("rst_B", B_out, '0);
    chk("rst_op_valid", W'(op_valid), W'(0));
    chk("rst_ser_ready", W'(ser_ready), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    rst_n = 1'b1; start = 1'b0; ser_valid = 1'b0; ser_in = 1'b0;
    tick();
    chk("rst_release_idle", W'(busy), W'(0));
  endtask

  task automatic test_basic();
    do_start();
    chk("basic_busy", W'(busy), W'(1));
    send_frame(4'b1001, 4'b0101, 1'b0, 1'b1);
    chk("basic_latency", W'(op_valid), W'(1));
    expect_pair("basic");
    handshake();
    chk("basic_idle_busy", W'(busy), W'(0));
    chk("basic_idle_valid", W'(op_valid), W'(0));
    chk("basic_hold_A", A_out, 4'b1001);
    chk("basic_hold_B", B_out, 4'b0101);
  endtask

  task automatic test_stall_backpressure();
    do_start();
    send_frame(4'b1100, 4'b1100, 1'b1, 1'b1);
    expect_pair("stall");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", W'(op_valid), W'(1));
      chk("bp_A", A_out, 4'b1100);
      chk("bp_B", B_out, 4'b1100);
    end
    handshake();
    for (int i = 0; i < 3; i++) begin
      chk("bp_once", W'(op_valid), W'(0));
      tick();
    end
    chk("bp_sb_empty", W'(sb.size()), W'(0));
  endtask

  task automatic test_back_to_back();
    do_start();
    send_frame(4'b1111, 4'b0000, 1'b0, 1'b1);
    expect_pair("b2b_first");
    start = 1'b1; op_ready = 1'b1;
    tick();
    start = 1'b0; op_ready = 1'b0;
    chk("b2b_no_bubble_ready", W'(ser_ready), W'(1));
    chk("b2b_no_bubble_busy", W'(busy), W'(1));
    chk("b2b_valid_drop", W'(op_valid), W'(0));
    send_frame(4'b0000, 4'b1111, 1'b0, 1'b1);
    chk("b2b_latency", W'(op_valid), W'(1));
    expect_pair("b2b_second");
    handshake();
  endtask

  task automatic test_ignored_inputs();
    for (int i = 0; i < 4; i++) begin
      ser_valid = i[0]; ser_in = 1'b1;
      tick();
      chk("ign_idle_busy", W'(busy), W'(0));
    end
    ser_valid = 1'b0;
    do_start();
    send_frame(4'b0011, 4'b0000, 1'b0, 1'b0);
    // Rerun on a fresh frame with a start pulse inside LOAD_B
    handshake();
    do_start();
    for (int i = W-1; i >= 0; i--) begin
      ser_valid = 1'b1; ser_in = i < 2;
      tick();
    end
    for (int i = W-1; i >= 0; i--) begin
      start = (i == 2); ser_valid = 1'b1; ser_in = i < 2;
      tick();
    end
    start = 1'b0; ser_valid = 1'b0;
    sb.push_back('{a: 4'b0011, b: 4'b0011, y: 4'b0011});
    expect_pair("ign");
    for (int i = 0; i < 4; i++) begin
      ser_valid = ~i[0]; ser_in = 1'b0;
      tick();
      chk("ign_present_A", A_out, 4'b0011);
      chk("ign_present_B", B_out, 4'b0011);
    end
    ser_valid = 1'b0;
    handshake();
    chk("ign_idle_after", W'(busy), W'(0));
  endtask

  task automatic test_abort();
    logic [2*W-1:0] bits;
    bits = {4'b0110, 4'b1000};
    do_start();
    for (int i = 2*W-1; i >= 1; i--) begin
      ser_valid = 1'b1; ser_in = bits[i];
      tick();
    end
    ser_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("abort_A", A_out, '0);
    chk("abort_B", B_out, '0);
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_ready", W'(ser_ready), W'(0));
    rst_n = 1'b1;
    tick();
    do_start();
    send_frame(4'b1001, 4'b0011, 1'b0, 1'b1);
    expect_pair("abort_fresh");
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_backpressure();
    test_back_to_back();
    test_ignored_inputs();
    test_abort();
    tests++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
